hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage single-issue CPU (IF, ID, EX, MEM, WR).
- Keeps its own scoreboard of in-flight destination registers and detects read-after-write hazards for the instruction in ID.
- Drives PC/IF-ID write enables, the IF/ID flush and the ID/EX bubble; flushes the wrong path when a branch resolves taken in EX.
- Counts stall cycles for performance debug. Sits beside the control decoder; consumes decoded ID fields and the EX-stage nPC_sel.

---
 rtl/hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage single-issue CPU
// (IF, ID, EX, MEM, WR). It tracks in-flight destination registers in its own
// scoreboard and detects read-after-write hazards for the instruction in ID.
// It drives the PC / IF-ID write enables, the IF/ID flush and the ID/EX
// bubble, and flushes the wrong path when a branch resolves taken in EX.
// A saturating counter records stall cycles for performance debug.
//
// Optional feature macro: HAZARD_FWD_EN
//   undefined : full stall interlock, no forwarding ports.
//   defined   : adds a retired-result slot and the EX operand-source selects
//               fwd_a / fwd_b; only load-use dependencies stall.
//
// Ports:
//   clk              in   system clock, rising edge
//   reset            in   asynchronous, active-high reset
//   id_valid         in   IF/ID holds a real instruction (0 = bubble)
//   id_rs, id_rt     in   ID source registers A / B
//   id_uses_rt       in   ID instruction reads rt
//   id_regwr         in   ID instruction writes the register file
//   id_rw            in   resolved destination of the ID instruction
//   id_memtoreg      in   ID instruction is a load
//   ex_branch_taken  in   nPC_sel from EX, branch taken this cycle
//   pc_wr            out  PC update enable
//   ifid_wr          out  IF/ID load enable
//   ifid_flush       out  clear IF/ID to a bubble on the next edge
//   idex_bubble      out  load a bubble into ID/EX on the next edge
//   stall_cnt        out  saturating count of stall cycles
//   fwd_a, fwd_b     out  (HAZARD_FWD_EN only) EX operand-source selects:
//                         0 regfile, 1 EX/MEM ALUout, 2 MEM/WR data,
//                         3 retired-result register
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_regwr,
   input  logic [4:0]       id_rw,
   input  logic             id_memtoreg,
   input  logic             ex_branch_taken,
   output logic             pc_wr,
   output logic             ifid_wr,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_cnt
`ifdef HAZARD_FWD_EN
   ,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
`endif
);

   // Slot index doubles as the forwarding select code: 1 MEM, 2 WB, 3 RET.
   localparam int SL_EX  = 0;
   localparam int SL_MEM = 1;
   localparam int SL_WB  = 2;
`ifdef HAZARD_FWD_EN
   localparam int NUM_SLOTS = 4;
`else
   localparam int NUM_SLOTS = 3;
`endif
   localparam int NUM_ID_SLOTS = 3;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   typedef struct packed {
      logic       valid;
      logic       regwr;
      logic [4:0] rw;
      logic       memtoreg;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
   } slot_t;

   slot_t            slot_reg  [NUM_SLOTS];
   slot_t            slot_next [NUM_SLOTS];
   slot_t            ex_next;
   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [NUM_ID_SLOTS-1:0] id_match;
   logic             id_valid_eff;
   logic             hazard;
   logic             flush;
   logic             stall;

   // A producer matches a consumer when it really writes a non-zero register
   // that the consumer reads. Writes to $0 never create a dependency.
   function automatic logic slot_hits(input slot_t s, input logic [4:0] ra,
                                      input logic [4:0] rb, input logic use_rb);
      return s.valid & s.regwr & (s.rw != 5'd0) &
             ((s.rw == ra) | (use_rb & (s.rw == rb)));
   endfunction

   // The instruction fetched down the wrong path sits in IF/ID during FLUSH.
   assign id_valid_eff = id_valid & (state_reg != ST_FLUSH);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ID_SLOTS; gi++) begin : g_id_match
         assign id_match[gi] = slot_hits(slot_reg[gi], id_rs, id_rt, id_uses_rt);
      end
   endgenerate

`ifdef HAZARD_FWD_EN
   // Everything but a load in EX can be forwarded.
   assign hazard = id_valid_eff & id_match[SL_EX] & slot_reg[SL_EX].memtoreg;
`else
   // The register file writes on the edge, so even a WB producer is not yet
   // visible to the ID read this cycle.
   assign hazard = id_valid_eff & (|id_match);
`endif

   assign flush = ex_branch_taken;
   assign stall = hazard & ~flush;

   // Only a non-stalled, non-flushed real instruction advances into EX.
   always_comb begin
      ex_next = '0;
      if (id_valid_eff && !stall && !flush) begin
         ex_next.valid    = 1'b1;
         ex_next.regwr    = id_regwr;
         ex_next.rw       = id_rw;
         ex_next.memtoreg = id_memtoreg;
         ex_next.rs       = id_rs;
         ex_next.rt       = id_rt;
         ex_next.uses_rt  = id_uses_rt;
      end
   end

   assign slot_next[SL_EX] = ex_next;
   generate
      for (gi = 1; gi < NUM_SLOTS; gi++) begin : g_slot_shift
         assign slot_next[gi] = slot_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_reg <= '{default: '0};
      end else begin
         slot_reg <= slot_next;
      end
   end

   // Flush outranks stall; STALL is left as soon as the hazard disappears.
   always_comb begin
      state_next = ST_RUN;
      if (flush) begin
         state_next = ST_FLUSH;
      end else if (stall) begin
         state_next = ST_STALL;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_reg <= '0;
      end else if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
         stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_reg;

   // Reset holds the front end frozen with bubbles entering both registers.
   always_comb begin
      pc_wr       = 1'b1;
      ifid_wr     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (reset) begin
         pc_wr       = 1'b0;
         ifid_wr     = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (flush) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (stall) begin
         pc_wr       = 1'b0;
         ifid_wr     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

`ifdef HAZARD_FWD_EN
   logic [NUM_SLOTS-1:1] a_hit;
   logic [NUM_SLOTS-1:1] b_hit;

   generate
      for (gi = 1; gi < NUM_SLOTS; gi++) begin : g_fwd_hit
         assign a_hit[gi] = slot_hits(slot_reg[gi], slot_reg[SL_EX].rs,
                                      slot_reg[SL_EX].rs, 1'b0);
         assign b_hit[gi] = slot_reg[SL_EX].uses_rt &
                            slot_hits(slot_reg[gi], slot_reg[SL_EX].rt,
                                      slot_reg[SL_EX].rt, 1'b0);
      end
   endgenerate

   // Youngest producer wins: MEM, then WB, then the retired result.
   always_comb begin
      fwd_a = 2'd0;
      fwd_b = 2'd0;
      if (slot_reg[SL_EX].valid) begin
         if (a_hit[1])      fwd_a = 2'd1;
         else if (a_hit[2]) fwd_a = 2'd2;
         else if (a_hit[3]) fwd_a = 2'd3;
         if (b_hit[1])      fwd_b = 2'd1;
         else if (b_hit[2]) fwd_b = 2'd2;
         else if (b_hit[3]) fwd_b = 2'd3;
      end
   end

   // Fields kept for completeness of the slot record but not consumed here.
   logic unused_bits;
   assign unused_bits = ^{slot_reg[0], slot_reg[1], slot_reg[2], slot_reg[3],
                          id_match, ST_STALL};
`else
   logic unused_bits;
   assign unused_bits = ^{slot_reg[0], slot_reg[1], slot_reg[2], SL_MEM,
                          SL_WB, ST_STALL};
`endif

endmodule
